// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's load/store port.
// Holds a word-organised RAM behind a request/ready handshake, inserting a
// fixed number of wait states between acceptance and the one-cycle response.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req_valid         request present (sampled in IDLE and RESP only)
//   mem_write         1 = store, 0 = load
//   byte_enable[3:0]  lane enables for write_data
//   addr[31:0]        byte address
//   write_data[31:0]  lane-aligned store data
//   read_data[31:0]   registered load data, valid while ready=1
//   ready             one-cycle response strobe
//   error             access fault flag, valid while ready=1
//
// Optional feature macro: DMEM_ERR_RESP_EN
//   defined   : out-of-window addresses and illegal lane patterns fault
//               (error=1, no write, read_data=0)
//   undefined : error stays 0; out-of-window stores are dropped and
//               out-of-window loads return 0
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_write,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        error
);

    localparam int unsigned DEPTH        = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W        = 8;
    localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH) << 2;
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_CYCLES != 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

`ifdef DMEM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             commit;

    // request captured at acceptance
    logic        lat_we;
    logic [3:0]  lat_be;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // request seen on the commit edge
    logic        cur_we;
    logic [3:0]  cur_be;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic [31:0]           offset;
    logic                  in_window;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  fault;

    logic [31:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; RESP accepts a new request just like IDLE
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES != 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end else begin
                        state_next = RESP;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        commit = (state_next == RESP);
    end

    // Request latch
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= mem_write;
            lat_be    <= byte_enable;
            lat_addr  <= addr;
            lat_wdata <= write_data;
        end
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // live inputs are used; otherwise the latched copy is.
    always_comb begin
        if (state == WAIT) begin
            cur_we    = lat_we;
            cur_be    = lat_be;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end else begin
            cur_we    = mem_write;
            cur_be    = byte_enable;
            cur_addr  = addr;
            cur_wdata = write_data;
        end
    end

    // Wrap-around subtraction makes addresses below the base land out of window
    assign offset    = cur_addr - BASE_ADDR;
    assign in_window = (offset < WINDOW_BYTES);
    assign word_idx  = offset[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_RESP_EN
    logic lane_ok;

    // Legal byte-enable patterns for the given byte offset
    always_comb begin
        lane_ok = 1'b0;
        case (cur_be)
            4'b1111, 4'b0011: lane_ok = (offset[1:0] == 2'd0);
            4'b1100:          lane_ok = (offset[1:0] == 2'd2);
            4'b0000:          lane_ok = cur_we;
            default:          lane_ok = (cur_be == (4'b0001 << offset[1:0]));
        endcase
    end

    assign fault = !in_window || !lane_ok;
`else
    logic unused_offset_lsb;

    assign unused_offset_lsb = ^offset[1:0];
    assign fault             = !in_window;
`endif

    // Response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= '0;
        end else begin
            ready <= commit;
            error <= commit && fault && ERR_EN;
            if (commit) begin
                if (fault) begin
                    if (!cur_we || ERR_EN) begin
                        read_data <= '0;
                    end
                end else if (!cur_we) begin
                    read_data <= mem[word_idx];
                end
            end
        end
    end

    // RAM write port; not reset, and reset on the commit edge blocks the write
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[word_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (1 and 0 wait states) share
// the request payload; each has its own req_valid. A transaction-level model
// predicts ready/error/read_data every cycle; directed transactions also
// carry hand-computed literal expectations.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 1024;

`ifdef DMEM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rv;
    logic        mem_write;
    logic [3:0]  byte_enable;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] rd0, rd1;
    logic [1:0]  rdy, erv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .mem_write(mem_write),
        .byte_enable(byte_enable), .addr(addr), .write_data(write_data),
        .read_data(rd0), .ready(rdy[0]), .error(erv[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .mem_write(mem_write),
        .byte_enable(byte_enable), .addr(addr), .write_data(write_data),
        .read_data(rd1), .ready(rdy[1]), .error(erv[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_rd(input int k);
        return (k == 0) ? rd0 : rd1;
    endfunction

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0] mm [int];
    bit          pv    [2];
    int          presp [2];
    logic        p_we  [2];
    logic [3:0]  p_be  [2];
    logic [31:0] p_addr[2];
    logic [31:0] p_data[2];
    logic        x_rdy [2];
    logic        x_err [2];
    logic [31:0] x_rd  [2];
    bit          primed = 0;
    int          cyc = 0;

    function automatic bit lanes_legal(input logic [3:0] be, input int a, input logic we);
        if (be == 4'b1111 && a == 0) return 1;
        if (be == 4'b0011 && a == 0) return 1;
        if (be == 4'b1100 && a == 2) return 1;
        if (be == 4'b0000) return we;
        for (int i = 0; i < 4; i++)
            if (a == i && be == 4'(1 << i)) return 1;
        return 0;
    endfunction

    task automatic model_respond(input int k);
        longint off;
        bit     inwin, flt;
        int     key;
        logic [31:0] w;
        off   = longint'(p_addr[k]) - longint'(BASE);
        inwin = (off >= 0) && (off < 4 * DEPTH);
        flt   = !inwin;
        if (ERR_EN && !lanes_legal(p_be[k], int'(p_addr[k] % 4), p_we[k])) flt = 1;
        key      = k * 100000 + int'(off / 4);
        x_rdy[k] = 1'b1;
        x_err[k] = ERR_EN && flt;
        if (flt) begin
            if (!p_we[k] || ERR_EN) x_rd[k] = 32'h0;
        end else if (p_we[k]) begin
            w = mm.exists(key) ? mm[key] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (p_be[k][i]) w[8*i +: 8] = p_data[k][8*i +: 8];
            mm[key] = w;
        end else begin
            x_rd[k] = mm.exists(key) ? mm[key] : 32'hx;
        end
    endtask

    // Compare this cycle's outputs, then advance the model over the next edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (primed) begin
                check($sformatf("model_ready%0d", k), 32'(rdy[k]), 32'(x_rdy[k]));
                check($sformatf("model_error%0d", k), 32'(erv[k]), 32'(x_err[k]));
                check($sformatf("model_rdata%0d", k), get_rd(k), x_rd[k]);
            end
            if (reset) begin
                pv[k]    = 0;
                x_rdy[k] = 1'b0;
                x_err[k] = 1'b0;
                x_rd[k]  = 32'h0;
            end else begin
                if (pv[k] && presp[k] == cyc) pv[k] = 0;
                if (!pv[k] && rv[k]) begin
                    pv[k]     = 1;
                    presp[k]  = cyc + wait_of(k) + 1;
                    p_we[k]   = mem_write;
                    p_be[k]   = byte_enable;
                    p_addr[k] = addr;
                    p_data[k] = write_data;
                end
                x_rdy[k] = 1'b0;
                x_err[k] = 1'b0;
                if (pv[k] && presp[k] == cyc + 1) model_respond(k);
            end
        end
        if (reset) primed = 1;
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tx(input int k, input logic we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        rv[k] = 1'b1; mem_write = we; byte_enable = be; addr = a; write_data = d;
        @(posedge clk); #1;
        rv[k] = 1'b0; mem_write = ~we; byte_enable = ~be; addr = 32'hFFFF_FFFF; write_data = ~d;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy[k]) begin
                lat = i; rd = get_rd(k); er = erv[k];
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) check("ready_timeout", 32'(lat), 32'(wait_of(k) + 1));
    endtask

    task automatic wr(input int k, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err, input string name);
        logic [31:0] rd; logic er; int lat;
        tx(k, 1'b1, be, a, d, rd, er, lat);
        check({name, "_lat"}, 32'(lat), 32'(wait_of(k) + 1));
        check({name, "_err"}, 32'(er), 32'(exp_err));
    endtask

    task automatic rdchk(input int k, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_err, input string name);
        logic [31:0] rd; logic er; int lat;
        tx(k, 1'b0, 4'b1111, a, 32'h0, rd, er, lat);
        check({name, "_lat"}, 32'(lat), 32'(wait_of(k) + 1));
        check({name, "_data"}, rd, exp_d);
        check({name, "_err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        logic [6:1] hist;
        reset = 1'b1; rv = 2'b00; mem_write = 1'b0; byte_enable = 4'h0;
        addr = 32'h0; write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(rdy), 32'h0);
        check("rst_error", 32'(erv), 32'h0);
        check("rst_rdata", rd0, 32'h0);

        // basic store/load and sub-word stores
        wr(0, 4'b1111, 32'h2004, 32'hDEADBEEF, 1'b0, "sw_2004");
        rdchk(0, 32'h2004, 32'hDEADBEEF, 1'b0, "lw_2004");
        wr(0, 4'b1000, 32'h2007, 32'hAB000000, 1'b0, "sb_2007");
        rdchk(0, 32'h2004, 32'hABADBEEF, 1'b0, "lw_after_sb");
        wr(0, 4'b1100, 32'h2006, 32'h12340000, 1'b0, "sh_2006");
        rdchk(0, 32'h2004, 32'h1234BEEF, 1'b0, "lw_after_sh");

        // back-to-back loads, one wait state: ready in cycles 2,4,6
        @(posedge clk); #1;
        rv[0] = 1'b1; mem_write = 1'b0; byte_enable = 4'b1111; addr = 32'h2004;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) rv[0] = 1'b0;
            @(negedge clk);
            hist[i] = rdy[0];
        end
        check("b2b_w1_pattern", 32'(hist), 32'(6'b101010));

        // back-to-back loads, zero wait states: ready in cycles 1,2,3
        @(posedge clk); #1;
        rv[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) rv[1] = 1'b0;
            @(negedge clk);
            hist[i] = rdy[1];
        end
        check("b2b_w0_pattern", 32'(hist[4:1]), 32'(4'b0111));

        // reset during the wait state drops the store
        wr(0, 4'b1111, 32'h2010, 32'h11111111, 1'b0, "sw_2010");
        @(posedge clk); #1;
        rv[0] = 1'b1; mem_write = 1'b1; byte_enable = 4'b1111;
        addr = 32'h2010; write_data = 32'h22222222;
        @(posedge clk); #1;
        rv[0] = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", 32'(rdy[0]), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(rdy), 32'h0);
        check("post_rst_error", 32'(erv), 32'h0);
        check("post_rst_rdata", rd0, 32'h0);
        rdchk(0, 32'h2010, 32'h11111111, 1'b0, "lw_2010_kept");

        // window and lane-pattern boundaries
        wr(0, 4'b1111, 32'h2000, 32'h0BADF00D, 1'b0, "sw_2000");
        rdchk(0, 32'h1FFC, 32'h0, ERR_EN, "lw_below_window");
        wr(0, 4'b1111, 32'h2005, 32'hFFFFFFFF, ERR_EN, "sw_misaligned");
        rdchk(0, 32'h2004, ERR_EN ? 32'h1234BEEF : 32'hFFFFFFFF, 1'b0, "lw_after_misaligned");
        wr(0, 4'b0000, 32'h2004, 32'h5A5A5A5A, 1'b0, "sw_no_lanes");
        rdchk(0, 32'h2004, ERR_EN ? 32'h1234BEEF : 32'hFFFFFFFF, 1'b0, "lw_after_no_lanes");
        wr(0, 4'b1111, 32'h3000, 32'h55555555, ERR_EN, "sw_above_window");
        rdchk(0, 32'h2000, 32'h0BADF00D, 1'b0, "lw_word0_kept");
        wr(0, 4'b1111, 32'h2FFC, 32'hCAFEF00D, 1'b0, "sw_top_word");
        rdchk(0, 32'h2FFC, 32'hCAFEF00D, 1'b0, "lw_top_word");
        wr(0, 4'b0010, 32'h2001, 32'h0000CD00, 1'b0, "sb_2001");
        rdchk(0, 32'h2000, 32'h0BADCD0D, 1'b0, "lw_after_sb_2001");

        // zero-wait instance
        wr(1, 4'b1111, 32'h2008, 32'h01234567, 1'b0, "w0_sw_2008");
        rdchk(1, 32'h2008, 32'h01234567, 1'b0, "w0_lw_2008");
        wr(1, 4'b0001, 32'h2008, 32'h000000EE, 1'b0, "w0_sb_2008");
        rdchk(1, 32'h2008, 32'h012345EE, 1'b0, "w0_lw_after_sb");

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
